cam_capture_ctrl: RTL and testbench

Parametrised successor to the camera-to-RAM capture stage. It converts the 8-bit camera byte stream (VSYNC/HREF framing) into pixel-wide write transactions for the input frame buffer. It adds:
- RGB565 or grayscale mode
- run-time decimation (1/2/4)
- enable/stop control
- overflow protection
- frame counting
- a ping-pong bank flag for the buffer controller.

It sits between the camera pins (pixel-clock domain) and the input buffer controller write port.

---
 rtl/cam_capture_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_cam_capture_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture_ctrl.sv
// -----------------------------------------------------------------------------
// cam_capture_ctrl
//
// Camera-to-frame-buffer capture stage. Turns the 8-bit camera byte stream
// (VSYNC/HREF framing) into one write per stored pixel for the input buffer
// controller. It supports RGB565 (two bytes per pixel, high byte first) or
// grayscale (one byte per pixel, expanded to RGB565), 1/2/4 decimation in both
// directions, frame counting, a ping-pong bank flag and an overflow guard.
// All logic runs on the camera pixel clock.
//
// Ports:
//   iClk        camera pixel clock, rising edge
//   iRst        synchronous active-high reset
//   iEnable     capture enable (level); a stop takes effect at frame end
//   iMode       0 = RGB565, 1 = gray (sampled at frame start)
//   iDecim      0 = keep all, 1 = every 2nd col/row, 2/3 = every 4th
//   iVsync      camera VSYNC, high = vertical blanking
//   iHsync      camera HREF, high = valid line bytes
//   iData       camera byte
//   oWrEn       one-cycle write strobe per stored pixel
//   oWrAddr     linear pixel address, restarts at 0 each frame
//   oWrData     RGB565 pixel
//   oFrameDone  one-cycle pulse at the end of a captured frame
//   oFrameCnt   completed-frame count, wraps
//   oBank       toggles at each oFrameDone (old value = bank just completed)
//   oOverflow   sticky per frame: a kept pixel fell beyond the buffer
//   oBusy       high while waiting for a frame or capturing one
// -----------------------------------------------------------------------------
module cam_capture_ctrl #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int DATA_W = 8,
    parameter int PIX_W  = 16,
    parameter int ADDR_W = 17,
    parameter int CNT_W  = 8
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iEnable,
    input  logic              iMode,
    input  logic [1:0]        iDecim,
    input  logic              iVsync,
    input  logic              iHsync,
    input  logic [DATA_W-1:0] iData,
    output logic              oWrEn,
    output logic [ADDR_W-1:0] oWrAddr,
    output logic [PIX_W-1:0]  oWrData,
    output logic              oFrameDone,
    output logic [CNT_W-1:0]  oFrameCnt,
    output logic              oBank,
    output logic              oOverflow,
    output logic              oBusy
);

    // One extra address bit so "address == buffer size" is representable even
    // when the buffer fills the whole ADDR_W space.
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(IMG_W * IMG_H);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_VS,
        S_ACTIVE,
        S_DONE
    } state_t;

    state_t            state;

    // Registered camera inputs plus one more stage for edge detection.
    logic              vs_r, vs_d;
    logic              hs_r, hs_d;
    logic [DATA_W-1:0] d_r;

    // Frame-scoped settings and counters.
    logic              mode_f;
    logic [1:0]        decim_f;
    logic              phase;      // RGB565 byte phase: 0 = expecting high byte
    logic [DATA_W-1:0] hi_byte;
    logic [1:0]        col;        // only col/row mod 4 matter for decimation
    logic [1:0]        row;
    logic [ADDR_W:0]   addr;

    logic              vs_fall, vs_rise, hs_fall;
    logic              pix_valid;
    logic              keep;
    logic [1:0]        dmask;
    logic [PIX_W-1:0]  pix;

    assign vs_fall = vs_d & ~vs_r;
    assign vs_rise = ~vs_d & vs_r;
    assign hs_fall = hs_d & ~hs_r;

    // NOTE: every output of always_comb gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        dmask = 2'b11;
        case (decim_f)
            2'd0:    dmask = 2'b00;
            2'd1:    dmask = 2'b01;
            default: dmask = 2'b11;
        endcase

        pix_valid = (state == S_ACTIVE) && hs_r && (mode_f || phase);
        keep      = ((col & dmask) == 2'b00) && ((row & dmask) == 2'b00);

        if (mode_f)
            pix = PIX_W'({d_r[DATA_W-1 -: 5], d_r[DATA_W-1 -: 6], d_r[DATA_W-1 -: 5]});
        else
            pix = PIX_W'({hi_byte, d_r});
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            vs_r <= 1'b0;
            vs_d <= 1'b0;
            hs_r <= 1'b0;
            hs_d <= 1'b0;
            d_r  <= '0;
        end else begin
            vs_r <= iVsync;
            vs_d <= vs_r;
            hs_r <= iHsync;
            hs_d <= hs_r;
            d_r  <= iData;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state      <= S_IDLE;
            mode_f     <= 1'b0;
            decim_f    <= 2'd0;
            phase      <= 1'b0;
            hi_byte    <= '0;
            col        <= 2'd0;
            row        <= 2'd0;
            addr       <= '0;
            oWrEn      <= 1'b0;
            oWrAddr    <= '0;
            oWrData    <= '0;
            oFrameDone <= 1'b0;
            oFrameCnt  <= '0;
            oBank      <= 1'b0;
            oOverflow  <= 1'b0;
            oBusy      <= 1'b0;
        end else begin
            oWrEn      <= 1'b0;
            oFrameDone <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (iEnable) begin
                        state <= S_WAIT_VS;
                        oBusy <= 1'b1;
                    end
                end

                // Only a full VSYNC falling edge starts a frame, so enabling
                // mid-frame never captures a partial image.
                S_WAIT_VS: begin
                    if (vs_fall) begin
                        state     <= S_ACTIVE;
                        mode_f    <= iMode;
                        decim_f   <= iDecim;
                        col       <= 2'd0;
                        row       <= 2'd0;
                        addr      <= '0;
                        phase     <= 1'b0;
                        oOverflow <= 1'b0;
                    end
                end

                S_ACTIVE: begin
                    if (hs_r) begin
                        if (!mode_f) begin
                            phase <= ~phase;
                            if (!phase)
                                hi_byte <= d_r;
                        end
                        if (pix_valid) begin
                            col <= col + 2'd1;
                            if (keep) begin
                                if (addr < ADDR_LIMIT) begin
                                    oWrEn   <= 1'b1;
                                    oWrAddr <= addr[ADDR_W-1:0];
                                    oWrData <= pix;
                                    addr    <= addr + (ADDR_W + 1)'(1);
                                end else begin
                                    oOverflow <= 1'b1;
                                end
                            end
                        end
                    end else if (hs_fall) begin
                        // Line end; a pending unpaired RGB565 byte is dropped.
                        row   <= row + 2'd1;
                        col   <= 2'd0;
                        phase <= 1'b0;
                    end

                    // A byte arriving with the VSYNC rise is still handled above.
                    if (vs_rise) begin
                        state      <= S_DONE;
                        oBusy      <= 1'b0;
                        oFrameDone <= 1'b1;
                        oFrameCnt  <= oFrameCnt + CNT_W'(1);
                        oBank      <= ~oBank;
                    end
                end

                S_DONE: begin
                    if (iEnable) begin
                        state <= S_WAIT_VS;
                        oBusy <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    oBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cam_capture_ctrl
//
// Directed bench for cam_capture_ctrl with a tiny 4x2 buffer (8 pixels) so
// the overflow boundary is reached with short frames. A monitor logs every
// write and frame-done pulse; the stimulus block checks the logs against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_cam_capture_ctrl;

    localparam int IMG_W  = 4;
    localparam int IMG_H  = 2;
    localparam int DATA_W = 8;
    localparam int PIX_W  = 16;
    localparam int ADDR_W = 3;
    localparam int CNT_W  = 8;

    logic              iClk = 1'b0;
    logic              iRst;
    logic              iEnable;
    logic              iMode;
    logic [1:0]        iDecim;
    logic              iVsync;
    logic              iHsync;
    logic [DATA_W-1:0] iData;
    logic              oWrEn;
    logic [ADDR_W-1:0] oWrAddr;
    logic [PIX_W-1:0]  oWrData;
    logic              oFrameDone;
    logic [CNT_W-1:0]  oFrameCnt;
    logic              oBank;
    logic              oOverflow;
    logic              oBusy;

    cam_capture_ctrl #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .DATA_W(DATA_W),
        .PIX_W (PIX_W),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iEnable   (iEnable),
        .iMode     (iMode),
        .iDecim    (iDecim),
        .iVsync    (iVsync),
        .iHsync    (iHsync),
        .iData     (iData),
        .oWrEn     (oWrEn),
        .oWrAddr   (oWrAddr),
        .oWrData   (oWrData),
        .oFrameDone(oFrameDone),
        .oFrameCnt (oFrameCnt),
        .oBank     (oBank),
        .oOverflow (oOverflow),
        .oBusy     (oBusy)
    );

    always #5 iClk = ~iClk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int done_cnt = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];
    int          drv_cyc_q[$];

    always @(posedge iClk) cyc++;

    always @(negedge iClk) begin
        if (oWrEn) begin
            wr_addr_q.push_back(32'(oWrAddr));
            wr_data_q.push_back(32'(oWrData));
            wr_cyc_q.push_back(cyc);
        end
        if (oFrameDone)
            done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wr_addr_at(input int i);
        return (i < wr_addr_q.size()) ? wr_addr_q[i] : 'x;
    endfunction

    function automatic logic [31:0] wr_data_at(input int i);
        return (i < wr_data_q.size()) ? wr_data_q[i] : 'x;
    endfunction

    function automatic logic [15:0] gray565(input logic [7:0] y);
        return {y[7:3], y[7:2], y[7:3]};
    endfunction

    task automatic tick();
        @(negedge iClk);
    endtask

    // Blanking then a VSYNC fall; leaves the DUT in ACTIVE when enabled.
    task automatic frame_start();
        iVsync = 1'b1;
        repeat (3) tick();
        iVsync = 1'b0;
        repeat (3) tick();
    endtask

    task automatic frame_end();
        iVsync = 1'b1;
        repeat (5) tick();
    endtask

    // One HREF line of nb incrementing bytes from base. Optionally drops
    // iEnable or pulses iRst together with a chosen byte.
    task automatic send_line(input logic [7:0] base, input int nb,
                             input int en_drop_at, input int rst_at);
        for (int b = 0; b < nb; b++) begin
            iHsync = 1'b1;
            iData  = base + 8'(b);
            drv_cyc_q.push_back(cyc);
            if (b == en_drop_at)
                iEnable = 1'b0;
            if (b == rst_at)
                iRst = 1'b1;
            tick();
            if (b == rst_at) begin
                iRst = 1'b0;
                check("rst_mid_wren",  32'(oWrEn),      32'h0);
                check("rst_mid_addr",  32'(oWrAddr),    32'h0);
                check("rst_mid_data",  32'(oWrData),    32'h0);
                check("rst_mid_done",  32'(oFrameDone), 32'h0);
                check("rst_mid_cnt",   32'(oFrameCnt),  32'h0);
                check("rst_mid_bank",  32'(oBank),      32'h0);
                check("rst_mid_ovf",   32'(oOverflow),  32'h0);
                check("rst_mid_busy",  32'(oBusy),      32'h0);
            end
        end
        iHsync = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        int wb;
        int db;
        int cb;
        int line;
        int col;

        iRst    = 1'b1;
        iEnable = 1'b0;
        iMode   = 1'b0;
        iDecim  = 2'd0;
        iVsync  = 1'b1;
        iHsync  = 1'b0;
        iData   = '0;
        repeat (3) tick();

        // Reset state
        check("reset_wren", 32'(oWrEn),      32'h0);
        check("reset_addr", 32'(oWrAddr),    32'h0);
        check("reset_data", 32'(oWrData),    32'h0);
        check("reset_done", 32'(oFrameDone), 32'h0);
        check("reset_cnt",  32'(oFrameCnt),  32'h0);
        check("reset_bank", 32'(oBank),      32'h0);
        check("reset_ovf",  32'(oOverflow),  32'h0);
        check("reset_busy", 32'(oBusy),      32'h0);
        iRst = 1'b0;
        tick();
        check("idle_busy", 32'(oBusy), 32'h0);

        // Frame 1: RGB565, decim 0, 2 lines x 8 bytes 0x00..0x0F
        iEnable = 1'b1;
        repeat (2) tick();
        check("wait_busy", 32'(oBusy), 32'h1);
        wb = wr_addr_q.size();
        db = done_cnt;
        frame_start();
        send_line(8'h00, 8, -1, -1);
        send_line(8'h08, 8, -1, -1);
        frame_end();
        check("f1_nwr", 32'(wr_addr_q.size() - wb), 32'd8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("f1_addr%0d", k), wr_addr_at(wb + k), 32'(k));
            check($sformatf("f1_data%0d", k), wr_data_at(wb + k),
                  32'({8'(2 * k), 8'(2 * k + 1)}));
        end
        check("f1_done", 32'(done_cnt - db), 32'd1);
        check("f1_cnt",  32'(oFrameCnt), 32'd1);
        check("f1_bank", 32'(oBank),     32'h1);
        check("f1_ovf",  32'(oOverflow), 32'h0);
        check("f1_busy", 32'(oBusy),     32'h1);

        // Frame 2: gray expansion and 2-cycle latency
        iMode = 1'b1;
        wb = wr_addr_q.size();
        frame_start();
        cb = drv_cyc_q.size();
        iHsync = 1'b1;
        iData  = 8'hFF;
        drv_cyc_q.push_back(cyc);
        tick();
        iData  = 8'h80;
        drv_cyc_q.push_back(cyc);
        tick();
        iHsync = 1'b0;
        repeat (2) tick();
        frame_end();
        check("f2_nwr",   32'(wr_addr_q.size() - wb), 32'd2);
        check("f2_data0", wr_data_at(wb),     32'hFFFF);
        check("f2_data1", wr_data_at(wb + 1), 32'h8410);
        check("f2_addr1", wr_addr_at(wb + 1), 32'd1);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("f2_lat%0d", k),
                  (wb + k < wr_cyc_q.size()) ? 32'(wr_cyc_q[wb + k] - drv_cyc_q[cb + k]) : 'x,
                  32'd2);
        end
        check("f2_cnt",  32'(oFrameCnt), 32'd2);
        check("f2_bank", 32'(oBank),     32'h0);

        // Frame 3: gray, decim 1, 4 lines x 8 bytes -> lines 0,2 cols 0,2,4,6
        iDecim = 2'd1;
        wb = wr_addr_q.size();
        frame_start();
        for (int l = 0; l < 4; l++)
            send_line(8'(8'h10 + 8 * l), 8, -1, -1);
        frame_end();
        check("f3_nwr", 32'(wr_addr_q.size() - wb), 32'd8);
        for (int k = 0; k < 8; k++) begin
            line = (k / 4) * 2;
            col  = (k % 4) * 2;
            check($sformatf("f3_addr%0d", k), wr_addr_at(wb + k), 32'(k));
            check($sformatf("f3_data%0d", k), wr_data_at(wb + k),
                  32'(gray565(8'(8'h10 + line * 8 + col))));
        end
        check("f3_ovf", 32'(oOverflow), 32'h0);

        // Frame 4: RGB565, 3 lines -> third line dropped, overflow set.
        // The mid-frame mode change must be ignored.
        iMode  = 1'b0;
        iDecim = 2'd0;
        wb = wr_addr_q.size();
        frame_start();
        iMode = 1'b1;
        for (int l = 0; l < 3; l++)
            send_line(8'(8'h20 + 8 * l), 8, -1, -1);
        frame_end();
        iMode = 1'b0;
        check("f4_nwr", 32'(wr_addr_q.size() - wb), 32'd8);
        for (int k = 0; k < 8; k++)
            check($sformatf("f4_data%0d", k), wr_data_at(wb + k),
                  32'({8'(8'h20 + 2 * k), 8'(8'h21 + 2 * k)}));
        check("f4_ovf", 32'(oOverflow), 32'h1);
        check("f4_cnt", 32'(oFrameCnt), 32'd4);

        // Frame 5: overflow clears at start; enable dropped during line 1
        wb = wr_addr_q.size();
        db = done_cnt;
        frame_start();
        check("f5_ovf_clr", 32'(oOverflow), 32'h0);
        send_line(8'h40, 8, -1, -1);
        send_line(8'h48, 8, 2, -1);
        frame_end();
        check("f5_nwr",   32'(wr_addr_q.size() - wb), 32'd8);
        check("f5_addr7", wr_addr_at(wb + 7), 32'd7);
        check("f5_data7", wr_data_at(wb + 7), 32'h4E4F);
        check("f5_done",  32'(done_cnt - db), 32'd1);
        check("f5_cnt",   32'(oFrameCnt), 32'd5);
        check("f5_busy",  32'(oBusy),     32'h0);

        // Enable while VSYNC is low: the frame in progress is skipped
        wb = wr_addr_q.size();
        db = done_cnt;
        frame_start();
        iEnable = 1'b1;
        tick();
        check("f6_busy", 32'(oBusy), 32'h1);
        send_line(8'h50, 8, -1, -1);
        send_line(8'h58, 8, -1, -1);
        frame_end();
        check("f6_nwr",  32'(wr_addr_q.size() - wb), 32'd0);
        check("f6_done", 32'(done_cnt - db), 32'd0);
        check("f6_cnt",  32'(oFrameCnt), 32'd5);

        // Next full frame is captured
        wb = wr_addr_q.size();
        frame_start();
        send_line(8'h60, 8, -1, -1);
        frame_end();
        check("f7_nwr",   32'(wr_addr_q.size() - wb), 32'd4);
        check("f7_addr0", wr_addr_at(wb),     32'd0);
        check("f7_data0", wr_data_at(wb),     32'h6061);
        check("f7_data3", wr_data_at(wb + 3), 32'h6667);
        check("f7_cnt",   32'(oFrameCnt), 32'd6);
        check("f7_bank",  32'(oBank),     32'h0);

        // Reset during line 1: no frame-done, rest of frame ignored
        db = done_cnt;
        frame_start();
        send_line(8'h70, 8, -1, -1);
        send_line(8'h78, 8, -1, 3);
        wb = wr_addr_q.size();
        frame_end();
        check("f8_nwr",  32'(wr_addr_q.size() - wb), 32'd0);
        check("f8_done", 32'(done_cnt - db), 32'd0);

        // Capture after reset restarts at address 0
        wb = wr_addr_q.size();
        frame_start();
        send_line(8'h90, 8, -1, -1);
        frame_end();
        check("f9_nwr",   32'(wr_addr_q.size() - wb), 32'd4);
        check("f9_addr0", wr_addr_at(wb), 32'd0);
        check("f9_data0", wr_data_at(wb), 32'h9091);
        check("f9_cnt",   32'(oFrameCnt), 32'd1);
        check("f9_bank",  32'(oBank),     32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
